// File: rtl/theta_d_apply.sv
// theta_d_apply: forms D[x] from column parity and XORs it into the state one plane per cycle
module theta_d_apply #(
  parameter int LANE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [25*LANE_W-1:0]  in_state,
  input  logic [5*LANE_W-1:0]   in_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [25*LANE_W-1:0]  out_state,
  output logic                  busy
);
  localparam int P = 5 * LANE_W;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state;
  logic [2:0]           cnt;
  logic [25*LANE_W-1:0] buffer;
  logic [P-1:0]         dreg;
  logic [P-1:0]         d;

  function automatic logic [LANE_W-1:0] rotl1(input logic [LANE_W-1:0] v);
    return {v[LANE_W-2:0], v[LANE_W-1]};
  endfunction

  // D[x] = C[x-1] ^ ROTL1(C[x+1]), indices mod 5
  always_comb begin
    d = '0;
    for (int x = 0; x < 5; x++)
      d[LANE_W*x +: LANE_W] = in_c[LANE_W*((x+4)%5) +: LANE_W] ^ rotl1(in_c[LANE_W*((x+1)%5) +: LANE_W]);
  end

  // Capture on accept, then XOR D into one plane per cycle until all five are done
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      buffer <= '0;
      dreg   <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        buffer <= in_state;
        dreg   <= d;
        cnt    <= '0;
        state  <= APPLY;
      end
    end else if (state == APPLY) begin
      if (cnt > 3'd4) begin
        cnt   <= '0;
        state <= IDLE;
      end else begin
        for (int y = 0; y < 5; y++)
          if (cnt == 3'(y)) buffer[P*y +: P] <= buffer[P*y +: P] ^ dreg;
        cnt   <= (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
        state <= (cnt == 3'd4) ? DONE : APPLY;
      end
    end else if (state == DONE) begin
      if (out_ready) state <= IDLE;
    end else begin
      state <= IDLE;
    end
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = (state == APPLY) || (state == DONE);
  assign out_state = buffer;
endmodule
